fetch_pc_unit: RTL and testbench

//   IF-stage program counter for the P5 pipelined core: holds PC_F and drives instruction-memory address.

---
 rtl/fetch_pc_unit_pkg.sv | 20 ++
 rtl/fetch_pc_unit_adder.sv | 13 +
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 tb/tb_fetch_pc_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared types and defaults for the IF-stage PC unit.
// Holds FSM state encodings, next-PC select codes and reset/step defaults.
package fetch_pc_unit_pkg;

   typedef enum logic [1:0] {
      FS_BOOT = 2'd0,
      FS_RUN  = 2'd1,
      FS_HALT = 2'd2
   } fs_e;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2
   } npc_sel_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_adder.sv
// fetch_pc_unit_adder: generic WIDTH-bit adder, result modulo 2^WIDTH.
// Ports: in1_i, in2_i operands; sum_o = in1_i + in2_i (carry discarded).
module fetch_pc_unit_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = in1_i + in2_i;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage PC register, next-PC mux and boot/run/halt FSM.
// Ports: clk, reset (sync, active-low), stall, br_valid/br_target,
//   j_valid/j_target, halt -> pc_F, pc_plus4_F, valid_F, align_err,
//   fetch_cnt (present only when macro FETCH_CNT_EN is defined).
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
   parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(DEF_PC_STEP)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             j_valid,
   input  logic [WIDTH-1:0] j_target,
   input  logic             halt,
   output logic [WIDTH-1:0] pc_F,
   output logic [WIDTH-1:0] pc_plus4_F,
   output logic             valid_F,
   output logic             align_err
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]      fetch_cnt
`endif
);

   fs_e              state_q;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] tgt;
   logic             err_q, err_d;
   npc_sel_e         sel;
   logic             adv;

   fetch_pc_unit_adder #(
      .WIDTH(WIDTH)
   ) u_pc_add (
      .in1_i(pc_q),
      .in2_i(PC_STEP),
      .sum_o(seq_pc)
   );

   // A fetch is accepted only in RUN, unstalled, and not halting.
   assign adv = (state_q == FS_RUN) && !stall && !halt;

   // j and br both valid is illegal upstream; j takes precedence.
   always_comb begin
      sel = NPC_SEQ;
      tgt = br_target;
      if (j_valid) begin
         sel = NPC_J;
         tgt = j_target;
      end else if (br_valid) begin
         sel = NPC_BR;
      end
   end

   always_comb begin
      pc_d  = pc_q;
      err_d = err_q;
      if (adv) begin
         if (sel == NPC_SEQ) begin
            pc_d = seq_pc;
         end else begin
            pc_d  = {tgt[WIDTH-1:2], 2'b00};
            err_d = err_q | (tgt[1:0] != 2'b00);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FS_BOOT;
         pc_q    <= RESET_PC;
         err_q   <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
         unique case (state_q)
            FS_BOOT: state_q <= FS_RUN;
            FS_RUN:  if (halt && !stall) state_q <= FS_HALT;
            FS_HALT: state_q <= FS_HALT;
            default: state_q <= FS_BOOT;
         endcase
      end
   end

   assign pc_F       = pc_q;
   assign pc_plus4_F = seq_pc;
   assign valid_F    = (state_q == FS_RUN);
   assign align_err  = err_q;

`ifdef FETCH_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (adv) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenarios then random stimulus for fetch_pc_unit,
// compared every cycle against a behavioural model of the PC rules.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset, stall, br_valid, j_valid, halt;
   logic [31:0] br_target, j_target;
   logic [31:0] pc_F, pc_plus4_F;
   logic        valid_F, align_err;
`ifdef FETCH_CNT_EN
   logic [31:0] fetch_cnt;
`endif

   int n_vec = 0;
   int n_bad = 0;

   // model state
   logic [31:0] m_pc;
   bit          m_boot, m_halted, m_err;
   int unsigned m_cnt;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .br_valid(br_valid),
      .br_target(br_target),
      .j_valid(j_valid),
      .j_target(j_target),
      .halt(halt),
      .pc_F(pc_F),
      .pc_plus4_F(pc_plus4_F),
      .valid_F(valid_F),
      .align_err(align_err)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt(fetch_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      if (!reset) begin
         m_pc = 32'h3000; m_boot = 1; m_halted = 0;
         m_err = 0; m_cnt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (!m_halted && !stall) begin
         if (halt) begin
            m_halted = 1;
         end else begin
            m_cnt++;
            if (j_valid) begin
               if (j_target % 4 != 0) m_err = 1;
               m_pc = j_target & 32'hFFFF_FFFC;
            end else if (br_valid) begin
               if (br_target % 4 != 0) m_err = 1;
               m_pc = br_target & 32'hFFFF_FFFC;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic cyc(input bit rst, input bit st, input bit bv,
                      input logic [31:0] bt, input bit jv,
                      input logic [31:0] jt, input bit h);
      reset = rst; stall = st; br_valid = bv; br_target = bt;
      j_valid = jv; j_target = jt; halt = h;
      @(posedge clk);
      model_edge();
      #1;
      chk("pc_F", pc_F, m_pc);
      chk("pc_plus4_F", pc_plus4_F, m_pc + 32'd4);
      chk("valid_F", {31'b0, valid_F}, {31'b0, !m_boot && !m_halted});
      chk("align_err", {31'b0, align_err}, {31'b0, m_err});
`ifdef FETCH_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 0; stall = 0; br_valid = 0; j_valid = 0; halt = 0;
      br_target = 0; j_target = 0;
      #1;
      // reset for two cycles
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h5000, 1, 32'h6000, 1);
      chk("rst_pc", pc_F, 32'h3000);
      chk("rst_valid", {31'b0, valid_F}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("boot_bubble_pc", pc_F, 32'h3000);
      chk("run_valid", {31'b0, valid_F}, 32'd1);
      seq(1);
      chk("seq_3004", pc_F, 32'h3004);
      seq(1);
      // stall three cycles at 0x3008
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);
      chk("stall_hold", pc_F, 32'h3008);
      seq(1);
      chk("stall_release", pc_F, 32'h300C);
      seq(1);
      // at 0x3010: stalled redirect is ignored
      cyc(1, 1, 1, 32'h3040, 1, 32'h3080, 0);
      chk("stall_redirect", pc_F, 32'h3010);
      cyc(1, 0, 1, 32'h3040, 1, 32'h3080, 0);
      chk("j_over_br", pc_F, 32'h3080);
      cyc(1, 0, 1, 32'h3040, 0, 0, 0);
      chk("br_taken", pc_F, 32'h3040);
      chk("aligned_no_err", {31'b0, align_err}, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'h3042, 0);
      chk("misalign_pc", pc_F, 32'h3040);
      chk("misalign_err", {31'b0, align_err}, 32'd1);
      seq(2);
      chk("err_sticky", {31'b0, align_err}, 32'd1);
      cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      seq(1);
      chk("wrap_zero", pc_F, 32'h0);
      cyc(1, 0, 0, 0, 1, 32'h3020, 0);
      // halt at 0x3020, then stalls and redirects ignored
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("halt_pc", pc_F, 32'h3020);
      chk("halt_valid", {31'b0, valid_F}, 32'd0);
      cyc(1, 0, 1, 32'h4000, 1, 32'h5000, 0);
      cyc(1, 1, 1, 32'h4000, 0, 0, 0);
      chk("halt_ignore", pc_F, 32'h3020);
      cyc(0, 1, 0, 0, 0, 0, 1);
      chk("rerst_pc", pc_F, 32'h3000);
      chk("rerst_err", {31'b0, align_err}, 32'd0);
      // 10 run cycles, 3 of them stalled
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, (i % 3 == 1), 0, 0, 0, 0, 0);
`ifdef FETCH_CNT_EN
      chk("cnt7", fetch_cnt, 32'd7);
`endif
      chk("cnt_run_pc", pc_F, 32'h3000 + 32'd28);
      // random phase
      for (int i = 0; i < 600; i++) begin
         bit rs, st, bv, jv, h;
         logic [31:0] bt, jt;
         rs = ($urandom_range(99) < 2);
         st = ($urandom_range(99) < 25);
         bv = ($urandom_range(99) < 20);
         jv = ($urandom_range(99) < 15);
         bt = $urandom;
         jt = $urandom;
         if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
         h = !bv && !jv && ($urandom_range(99) < 3);
         cyc(!rs, st, bv, bt, jv, jt, h);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
